spi_btn_frame_decoder: RTL

- Sits directly downstream of spi_dev_core. Parses its MOSI byte stream and chip-select edges into button-state reports.
- Accepts only frames whose first byte is CMD_ID and which carry exactly N_BYTES payload bytes. Commits the payload atomically on CS deassert.
- Emits per-bit press/release event vectors, an update strobe, and a malformed-frame counter.
- Feeds the LED/application logic in place of ad-hoc capture registers.

---
 rtl/spi_btn_frame_decoder.sv | 103 ++++++++++
 1 files changed

// File: rtl/spi_btn_frame_decoder.sv
// Parses spi_dev_core MOSI bytes and chip-select edges into button reports.
// The payload is committed atomically on CS deassert, and only for a well-formed report frame.
module spi_btn_frame_decoder #(
  parameter logic [7:0]  CMD_ID  = 8'hF4,
  parameter int unsigned N_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           usr_mosi_data,
  input  logic                 usr_mosi_stb,
  input  logic                 csn_fall,
  input  logic                 csn_rise,
  output logic [8*N_BYTES-1:0] btn_state,
  output logic [8*N_BYTES-1:0] btn_pressed,
  output logic [8*N_BYTES-1:0] btn_released,
  output logic                 update_stb,
  output logic [7:0]           frame_err_cnt
);

  localparam int unsigned W = 8 * N_BYTES;

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDiscard} state_e;

  state_e         state_q, state_d;
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [W-1:0]   btn_state_q, btn_state_d;
  logic [W-1:0]   pressed_q, pressed_d;
  logic [W-1:0]   released_q, released_d;
  logic           update_q, update_d;
  logic [7:0]     err_q, err_d;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shadow_d    = shadow_q;
    btn_state_d = btn_state_q;
    pressed_d   = '0;
    released_d  = '0;
    update_d    = 1'b0;
    err_d       = err_q;

    if (csn_fall) begin
      // Frame start wins over any coincident rise or byte.
      state_d    = StCmd;
      byte_cnt_d = '0;
      shadow_d   = '0;
    end else if (csn_rise) begin
      state_d = StIdle;
      if (state_q == StData) begin
        if (byte_cnt_q == 4'(N_BYTES)) begin
          btn_state_d = shadow_q;
          pressed_d   = shadow_q & ~btn_state_q;
          released_d  = btn_state_q & ~shadow_q;
          update_d    = 1'b1;
        end else if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
      end
    end else if (usr_mosi_stb) begin
      unique case (state_q)
        StCmd: state_d = (usr_mosi_data == CMD_ID) ? StData : StDiscard;
        StData: begin
          // Truncating cast keeps the low W bits, so this also covers N_BYTES == 1.
          shadow_d = W'({shadow_q, usr_mosi_data});
          if (byte_cnt_q != 4'(N_BYTES + 1)) begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      shadow_q    <= '0;
      btn_state_q <= '0;
      pressed_q   <= '0;
      released_q  <= '0;
      update_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shadow_q    <= shadow_d;
      btn_state_q <= btn_state_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
      update_q    <= update_d;
      err_q       <= err_d;
    end
  end

  assign btn_state     = btn_state_q;
  assign btn_pressed   = pressed_q;
  assign btn_released  = released_q;
  assign update_stb    = update_q;
  assign frame_err_cnt = err_q;

endmodule
